trace_id_decoder: RTL and testbench
===================================

# trace_id_decoder

Reconstructs the 32-bit control-flow trace stream from the compressed ID stream produced by the attestation front end. Each token is either a define, which binds a new ID to a trace word, or a reference, which reuses an already-defined ID. The block maintains an ID→trace dictionary in inferred synchronous RAM and emits one reconstructed trace per accepted token through a ready/valid output FIFO. It sits on the verifier side, between the token link and the path-check logic.

## Interface
- ID_W, 13, token ID width; dictionary depth is 2**ID_W.
- TRACE_W, 32, trace word width.
- FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2.
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high; clock clk
- in_valid  in  1  input token valid
- in_ready  out  1  input token accepted when in_valid && in_ready
- in_is_define  in  1  1 = define token, 0 = reference token
- in_id  in  ID_W  token ID
- in_trace  in  TRACE_W  trace word; used for defines only
- out_valid  out  1  output FIFO head valid
- out_ready  in  1  consumer pops the head when out_valid && out_ready
- out_trace  out  TRACE_W  reconstructed trace; 0 on error tokens
- out_id  out  ID_W  ID of the token
- out_error  out  1  token was invalid (see Operation)
- dict_count  out  ID_W+1  number of defined IDs
- dict_full  out  1  dict_count == 2**ID_W
- stat_refs  out  32  accepted reference tokens
- stat_errors  out  16  accepted error tokens, saturating

## Operation
- **Validity.** Validity is decided at the accept edge against the current dict_count.
  - Define is valid iff in_id == dict_count[ID_W-1:0] and !dict_full. It writes RAM[in_id] = in_trace at the accept edge and increments dict_count.
  - Reference is valid iff in_id < dict_count.
  - Invalid token: no RAM write and no count change. It still produces an output entry with out_error=1 and out_trace=0.
- **Output.** Every accepted token produces exactly one output entry, in acceptance order.
  - Define: out_trace = in_trace, taken from the pipeline register, not from RAM.
  - Reference: out_trace = RAM read data.
- **Pipeline.**
  - Stage A registers {is_define, id, trace, error} on accept and drives the RAM read address.
  - RAM read is synchronous and read-first.
  - Stage B holds the RAM data and pushes the entry into the FIFO on the next edge.
  - Stages advance unconditionally; backpressure is applied only at in_ready.
- **Flow control.** in_ready = (fifo_count + valid_A + valid_B) < FIFO_DEPTH, combinational from registers. A token in flight therefore always has a FIFO slot.
- **RAM hazard.** A same-address read-during-write needs no bypass. It only arises when a reference to X precedes the define of X, and that reference is already flagged invalid.
- **FIFO.** Simultaneous push and pop on a full FIFO is allowed; the count is unchanged. out_trace, out_id and out_error are 0 whenever out_valid=0.
- **Dictionary full.** Once dict_count reaches 2**ID_W, dict_full=1 and every further define is an error. dict_count never wraps.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_trace=0, out_id=0, out_error=0.
  - dict_count=0, dict_full=0, stat_refs=0, stat_errors=0.
  - Stages A/B invalid, FIFO empty.
- RAM contents are not cleared. dict_count=0 makes all stale contents unreachable.
- Latency: token accepted at edge k → out_valid=1 after edge k+2 if the FIFO was empty.
- Throughput: one token per cycle while out_ready=1.
- Reset asserted mid-operation discards in-flight and FIFO contents immediately. No output is produced for them.

## Configuration
- TRACE_DEC_STATS_EN defined:
  - stat_refs increments on each accepted valid reference, and wraps.
  - stat_errors increments on each accepted invalid token and saturates at 16'hFFFF.
- TRACE_DEC_STATS_EN not defined: the counters are not built, and stat_refs and stat_errors are tied to 0.

## Test plan
- **Basic define/reference.** After reset, define id 0 trace 0xDEADBEEF, then reference id 0 → two outputs, both out_trace=0xDEADBEEF, out_error=0, dict_count=1; first out_valid two cycles after accept.
- **Out-of-order define.** Define id 5 with dict_count=0 → out_error=1, out_trace=0, dict_count stays 0. Next define id 0 is accepted as valid.
- **Undefined reference.** Reference id 3 with dict_count=3 → out_error=1; stat_errors=1 when TRACE_DEC_STATS_EN is defined.
- **Backpressure.** Hold out_ready=0 and stream defines 0..9 → in_ready drops after 4 accepts. Release out_ready → traces for ids 0..9 arrive in order with no loss or duplication.
- **Dictionary full.** With ID_W=3, define ids 0..7 then define id 0 → dict_full=1, ninth output out_error=1. Reference id 7 returns its trace.
- **Reset mid-stream.** Assert reset with 3 tokens in flight → out_valid=0 and dict_count=0. A reference to id 0 after reset gives out_error=1.

Source files
------------

// File: rtl/trace_id_decoder.sv
// Compressed trace-ID stream decoder: ID->trace dictionary in synchronous RAM, a two-stage pipeline and an output FIFO.
// Optional statistics counters are built only when TRACE_DEC_STATS_EN is defined.
module trace_id_decoder #(
   parameter int ID_W       = 13,
   parameter int TRACE_W    = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_is_define,
   input  logic [ID_W-1:0]    in_id,
   input  logic [TRACE_W-1:0] in_trace,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [TRACE_W-1:0] out_trace,
   output logic [ID_W-1:0]    out_id,
   output logic               out_error,
   output logic [ID_W:0]      dict_count,
   output logic               dict_full,
   output logic [31:0]        stat_refs,
   output logic [15:0]        stat_errors
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [ID_W:0] DICT_MAX = {1'b1, {ID_W{1'b0}}};

   logic               accept;
   logic               def_ok;
   logic               ref_ok;
   logic               tok_err;
   logic               wr_en;
   logic [CNT_W:0]     occupancy;

   logic               vld_p0;
   logic               is_def_p0;
   logic [ID_W-1:0]    id_p0;
   logic [TRACE_W-1:0] trace_p0;
   logic               err_p0;

   logic               vld_p1;
   logic               is_def_p1;
   logic [ID_W-1:0]    id_p1;
   logic [TRACE_W-1:0] trace_p1;
   logic               err_p1;
   logic [TRACE_W-1:0] ram_q_p1;

   logic [TRACE_W-1:0] ram [2**ID_W];

   logic               push;
   logic               pop;
   logic [TRACE_W-1:0] push_trace;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   fifo_count;
   logic [TRACE_W-1:0] fifo_trace [FIFO_DEPTH];
   logic [ID_W-1:0]    fifo_id    [FIFO_DEPTH];
   logic               fifo_err   [FIFO_DEPTH];

   // Accept decision and token validity against the current dictionary size
   assign accept  = in_valid && in_ready;
   assign def_ok  = (in_id == dict_count[ID_W-1:0]) && !dict_full;
   assign ref_ok  = ({1'b0, in_id} < dict_count);
   assign tok_err = in_is_define ? !def_ok : !ref_ok;
   assign wr_en   = accept && in_is_define && def_ok;

   // Tokens already in the pipeline are counted so every one has a FIFO slot when it lands
   assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, vld_p0} + {{CNT_W{1'b0}}, vld_p1};
   assign in_ready  = (occupancy < (CNT_W+1)'(FIFO_DEPTH));

   assign dict_full = (dict_count == DICT_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dict_count <= '0;
      end else if (wr_en) begin
         dict_count <= dict_count + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p0 <= accept;
         vld_p1 <= vld_p0;
      end
   end

   // Stage A: token captured at accept, its id addresses the RAM read
   always_ff @(posedge clk) begin
      if (accept) begin
         is_def_p0 <= in_is_define;
         id_p0     <= in_id;
         trace_p0  <= in_trace;
         err_p0    <= tok_err;
      end
   end

   // Stage B: token plus read-first RAM data
   always_ff @(posedge clk) begin
      is_def_p1 <= is_def_p0;
      id_p1     <= id_p0;
      trace_p1  <= trace_p0;
      err_p1    <= err_p0;
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         ram[in_id] <= in_trace;
      end
      ram_q_p1 <= ram[id_p0];
   end

   // Output FIFO: stage B pushes unconditionally
   assign push       = vld_p1;
   assign out_valid  = (fifo_count != '0);
   assign pop        = out_valid && out_ready;
   assign push_trace = err_p1 ? '0 : (is_def_p1 ? trace_p1 : ram_q_p1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_trace[wr_ptr] <= push_trace;
         fifo_id[wr_ptr]    <= id_p1;
         fifo_err[wr_ptr]   <= err_p1;
      end
   end

   assign out_trace = out_valid ? fifo_trace[rd_ptr] : '0;
   assign out_id    = out_valid ? fifo_id[rd_ptr]    : '0;
   assign out_error = out_valid ? fifo_err[rd_ptr]   : 1'b0;

`ifdef TRACE_DEC_STATS_EN
   logic [31:0] refs_q;
   logic [15:0] errs_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         refs_q <= '0;
         errs_q <= '0;
      end else begin
         if (accept && !in_is_define && ref_ok) begin
            refs_q <= refs_q + 1'b1;
         end
         if (accept && tok_err && (errs_q != 16'hFFFF)) begin
            errs_q <= errs_q + 1'b1;
         end
      end
   end

   assign stat_refs   = refs_q;
   assign stat_errors = errs_q;
`else
   assign stat_refs   = '0;
   assign stat_errors = '0;
`endif

endmodule

// File: tb/tb_trace_id_decoder.sv
// Directed-vector bench for trace_id_decoder: a default-size instance plus an ID_W=3 instance for the full-dictionary case.
module tb_trace_id_decoder;

   typedef struct {
      logic [31:0] trace;
      logic [12:0] id;
      logic        err;
   } ent_t;

`ifdef TRACE_DEC_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic        clk;
   logic        reset;

   logic        in_valid, in_ready, in_is_define;
   logic [12:0] in_id;
   logic [31:0] in_trace;
   logic        out_valid, out_ready, out_error;
   logic [31:0] out_trace;
   logic [12:0] out_id;
   logic [13:0] dict_count;
   logic        dict_full;
   logic [31:0] stat_refs;
   logic [15:0] stat_errors;

   logic        s_in_valid, s_in_ready, s_in_is_define;
   logic [2:0]  s_in_id;
   logic [31:0] s_in_trace;
   logic        s_out_valid, s_out_ready, s_out_error;
   logic [31:0] s_out_trace;
   logic [2:0]  s_out_id;
   logic [3:0]  s_dict_count;
   logic        s_dict_full;
   logic [31:0] s_stat_refs;
   logic [15:0] s_stat_errors;

   int vectors;
   int miscompares;
   int to_cnt;
   ent_t got[$];
   ent_t got_s[$];

   trace_id_decoder #(.ID_W(13), .TRACE_W(32), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_is_define(in_is_define),
      .in_id(in_id), .in_trace(in_trace),
      .out_valid(out_valid), .out_ready(out_ready), .out_trace(out_trace),
      .out_id(out_id), .out_error(out_error),
      .dict_count(dict_count), .dict_full(dict_full),
      .stat_refs(stat_refs), .stat_errors(stat_errors)
   );

   trace_id_decoder #(.ID_W(3), .TRACE_W(32), .FIFO_DEPTH(4)) dut_s (
      .clk(clk), .reset(reset),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_is_define(s_in_is_define),
      .in_id(s_in_id), .in_trace(s_in_trace),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_trace(s_out_trace),
      .out_id(s_out_id), .out_error(s_out_error),
      .dict_count(s_dict_count), .dict_full(s_dict_full),
      .stat_refs(s_stat_refs), .stat_errors(s_stat_errors)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (out_valid && out_ready) got.push_back('{out_trace, out_id, out_error});
      if (s_out_valid && s_out_ready) got_s.push_back('{s_out_trace, {10'd0, s_out_id}, s_out_error});
   end

   task automatic do_reset;
      reset = 1'b1;
      in_valid = 1'b0;
      s_in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      got.delete();
      got_s.delete();
   endtask

   task automatic send(input logic def, input logic [12:0] id, input logic [31:0] tr);
      int n;
      in_valid = 1'b1; in_is_define = def; in_id = id; in_trace = tr;
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) to_cnt++;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_s(input logic def, input logic [2:0] id, input logic [31:0] tr);
      int n;
      s_in_valid = 1'b1; s_in_is_define = def; s_in_id = id; s_in_trace = tr;
      n = 0;
      while (!s_in_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) to_cnt++;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
   endtask

   task automatic wait_out(input int n);
      for (int c = 0; c < 200 && got.size() < n; c++) begin @(posedge clk); #1; end
   endtask

   task automatic wait_out_s(input int n);
      for (int c = 0; c < 200 && got_s.size() < n; c++) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset;
      do_reset();
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      vectors++; if (out_trace !== 32'd0) begin miscompares++; $display("FAIL rst_out_trace got %h want 0", out_trace); end
      vectors++; if (out_id !== 13'd0) begin miscompares++; $display("FAIL rst_out_id got %h want 0", out_id); end
      vectors++; if (out_error !== 1'b0) begin miscompares++; $display("FAIL rst_out_error got %b want 0", out_error); end
      vectors++; if (dict_count !== 14'd0) begin miscompares++; $display("FAIL rst_dict_count got %0d want 0", dict_count); end
      vectors++; if (dict_full !== 1'b0) begin miscompares++; $display("FAIL rst_dict_full got %b want 0", dict_full); end
      vectors++; if (stat_refs !== 32'd0) begin miscompares++; $display("FAIL rst_stat_refs got %0d want 0", stat_refs); end
      vectors++; if (stat_errors !== 16'd0) begin miscompares++; $display("FAIL rst_stat_errors got %0d want 0", stat_errors); end
   endtask

   task automatic test_basic;
      do_reset();
      out_ready = 1'b1;
      send(1'b1, 13'd0, 32'hDEADBEEF);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL lat_k0 out_valid got %b want 0", out_valid); end
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL lat_k1 out_valid got %b want 0", out_valid); end
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL lat_k2 out_valid got %b want 1", out_valid); end
      vectors++; if (out_trace !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lat_k2 out_trace got %h want deadbeef", out_trace); end
      send(1'b0, 13'd0, 32'h0);
      wait_out(2);
      vectors++; if (got.size() != 2) begin miscompares++; $display("FAIL basic_count got %0d want 2", got.size()); end
      if (got.size() >= 2) begin
         vectors++; if (got[0].trace !== 32'hDEADBEEF || got[0].err !== 1'b0) begin miscompares++; $display("FAIL basic_def got %h/%b want deadbeef/0", got[0].trace, got[0].err); end
         vectors++; if (got[1].trace !== 32'hDEADBEEF || got[1].err !== 1'b0) begin miscompares++; $display("FAIL basic_ref got %h/%b want deadbeef/0", got[1].trace, got[1].err); end
      end
      vectors++; if (dict_count !== 14'd1) begin miscompares++; $display("FAIL basic_dict_count got %0d want 1", dict_count); end
      vectors++; if (to_cnt != 0) begin miscompares++; $display("FAIL basic_accept_timeout got %0d want 0", to_cnt); end
      to_cnt = 0;
   endtask

   task automatic test_out_of_order;
      do_reset();
      out_ready = 1'b1;
      send(1'b1, 13'd5, 32'h11112222);
      vectors++; if (dict_count !== 14'd0) begin miscompares++; $display("FAIL ooo_dict_count got %0d want 0", dict_count); end
      send(1'b1, 13'd0, 32'h33334444);
      wait_out(2);
      vectors++; if (got.size() != 2) begin miscompares++; $display("FAIL ooo_count got %0d want 2", got.size()); end
      if (got.size() >= 2) begin
         vectors++; if (got[0].err !== 1'b1 || got[0].trace !== 32'd0 || got[0].id !== 13'd5) begin miscompares++; $display("FAIL ooo_bad got %b/%h/%0d want 1/0/5", got[0].err, got[0].trace, got[0].id); end
         vectors++; if (got[1].err !== 1'b0 || got[1].trace !== 32'h33334444) begin miscompares++; $display("FAIL ooo_good got %b/%h want 0/33334444", got[1].err, got[1].trace); end
      end
      vectors++; if (dict_count !== 14'd1) begin miscompares++; $display("FAIL ooo_dict_after got %0d want 1", dict_count); end
      vectors++; if (stat_errors !== 16'(STATS)) begin miscompares++; $display("FAIL ooo_stat_errors got %0d want %0d", stat_errors, STATS); end
   endtask

   task automatic test_undefined_ref;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) send(1'b1, 13'(i), 32'h100 + 32'(i));
      send(1'b0, 13'd3, 32'h0);
      send(1'b0, 13'd1, 32'h0);
      wait_out(5);
      vectors++; if (got.size() != 5) begin miscompares++; $display("FAIL undef_count got %0d want 5", got.size()); end
      if (got.size() >= 5) begin
         vectors++; if (got[3].err !== 1'b1 || got[3].trace !== 32'd0 || got[3].id !== 13'd3) begin miscompares++; $display("FAIL undef_ref got %b/%h/%0d want 1/0/3", got[3].err, got[3].trace, got[3].id); end
         vectors++; if (got[4].err !== 1'b0 || got[4].trace !== 32'h101) begin miscompares++; $display("FAIL undef_good_ref got %b/%h want 0/101", got[4].err, got[4].trace); end
      end
      vectors++; if (dict_count !== 14'd3) begin miscompares++; $display("FAIL undef_dict_count got %0d want 3", dict_count); end
      vectors++; if (stat_errors !== 16'(STATS)) begin miscompares++; $display("FAIL undef_stat_errors got %0d want %0d", stat_errors, STATS); end
      vectors++; if (stat_refs !== 32'(STATS)) begin miscompares++; $display("FAIL undef_stat_refs got %0d want %0d", stat_refs, STATS); end
   endtask

   task automatic test_backpressure;
      int  acc;
      logic take;
      do_reset();
      out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 8; c++) begin
         in_valid = 1'b1; in_is_define = 1'b1; in_id = 13'(acc); in_trace = 32'hA0000000 + 32'(acc);
         take = in_ready;
         @(posedge clk); #1;
         if (take) acc++;
      end
      in_valid = 1'b0;
      vectors++; if (acc != 4) begin miscompares++; $display("FAIL bp_accepts got %0d want 4", acc); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
      vectors++; if (got.size() != 0) begin miscompares++; $display("FAIL bp_no_pop got %0d want 0", got.size()); end
      out_ready = 1'b1;
      for (int i = acc; i < 10; i++) send(1'b1, 13'(i), 32'hA0000000 + 32'(i));
      wait_out(10);
      repeat (6) begin @(posedge clk); #1; end
      vectors++; if (got.size() != 10) begin miscompares++; $display("FAIL bp_count got %0d want 10", got.size()); end
      if (got.size() >= 10) begin
         for (int i = 0; i < 10; i++) begin
            vectors++;
            if (got[i].trace !== 32'hA0000000 + 32'(i) || got[i].id !== 13'(i) || got[i].err !== 1'b0) begin
               miscompares++; $display("FAIL bp_entry%0d got %h/%0d/%b want %h/%0d/0", i, got[i].trace, got[i].id, got[i].err, 32'hA0000000 + 32'(i), i);
            end
         end
      end
      vectors++; if (dict_count !== 14'd10) begin miscompares++; $display("FAIL bp_dict_count got %0d want 10", dict_count); end
   endtask

   task automatic test_dict_full;
      do_reset();
      s_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) send_s(1'b1, 3'(i), 32'hC0000000 + 32'(i));
      vectors++; if (s_dict_full !== 1'b1 || s_dict_count !== 4'd8) begin miscompares++; $display("FAIL full_flag got %b/%0d want 1/8", s_dict_full, s_dict_count); end
      send_s(1'b1, 3'd0, 32'h55555555);
      send_s(1'b0, 3'd7, 32'h0);
      wait_out_s(10);
      vectors++; if (got_s.size() != 10) begin miscompares++; $display("FAIL full_count got %0d want 10", got_s.size()); end
      if (got_s.size() >= 10) begin
         vectors++; if (got_s[8].err !== 1'b1 || got_s[8].trace !== 32'd0) begin miscompares++; $display("FAIL full_ninth got %b/%h want 1/0", got_s[8].err, got_s[8].trace); end
         vectors++; if (got_s[9].err !== 1'b0 || got_s[9].trace !== 32'hC0000007) begin miscompares++; $display("FAIL full_ref7 got %b/%h want 0/c0000007", got_s[9].err, got_s[9].trace); end
      end
      vectors++; if (s_dict_count !== 4'd8) begin miscompares++; $display("FAIL full_no_wrap got %0d want 8", s_dict_count); end
      vectors++; if (to_cnt != 0) begin miscompares++; $display("FAIL full_accept_timeout got %0d want 0", to_cnt); end
      to_cnt = 0;
   endtask

   task automatic test_reset_mid;
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(1'b1, 13'(i), 32'h77770000 + 32'(i));
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre_valid got %b want 1", out_valid); end
      reset = 1'b1;
      #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
      vectors++; if (dict_count !== 14'd0) begin miscompares++; $display("FAIL mid_dict_count got %0d want 0", dict_count); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
      @(posedge clk); #1;
      reset = 1'b0;
      got.delete();
      out_ready = 1'b1;
      send(1'b0, 13'd0, 32'h0);
      wait_out(1);
      repeat (6) begin @(posedge clk); #1; end
      vectors++; if (got.size() != 1) begin miscompares++; $display("FAIL mid_count got %0d want 1", got.size()); end
      if (got.size() >= 1) begin
         vectors++; if (got[0].err !== 1'b1 || got[0].trace !== 32'd0) begin miscompares++; $display("FAIL mid_ref0 got %b/%h want 1/0", got[0].err, got[0].trace); end
      end
      vectors++; if (to_cnt != 0) begin miscompares++; $display("FAIL mid_accept_timeout got %0d want 0", to_cnt); end
   endtask

   initial begin
      vectors = 0; miscompares = 0; to_cnt = 0;
      reset = 1'b1;
      in_valid = 1'b0; in_is_define = 1'b0; in_id = '0; in_trace = '0; out_ready = 1'b1;
      s_in_valid = 1'b0; s_in_is_define = 1'b0; s_in_id = '0; s_in_trace = '0; s_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_out_of_order();
      test_undefined_ref();
      test_backpressure();
      test_dict_full();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

endmodule
